// File: rtl/multiplier_32x32_pkg.sv
// Shared constants and types for the pipelined 32x32 multiplier.
package multiplier_32x32_pkg;

    localparam int unsigned MUL_WIDTH   = 32;
    localparam int unsigned MUL_LATENCY = 3;

    typedef logic [2*MUL_WIDTH-1:0] product_t;

endpackage

// File: rtl/mult_half.sv
// Combinational unsigned HxH -> 2H multiplier used for the partial products.
module mult_half #(
    parameter int unsigned H = 16
) (
    input  logic [H-1:0]   x,
    input  logic [H-1:0]   y,
    output logic [2*H-1:0] z
);

    // Operands widen to 2H in this context, so the product is exact.
    assign z = x * y;

endmodule

// File: rtl/multiplier_32x32.sv
// Three-stage pipelined unsigned multiplier: register inputs, form four
// half-width partial products, then sum them into the full-width product.
module multiplier_32x32
    import multiplier_32x32_pkg::*;
#(
    parameter int unsigned WIDTH   = MUL_WIDTH,
    parameter int unsigned LATENCY = MUL_LATENCY
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned H = WIDTH / 2;

    // The pipeline depth is structural; catch mismatched overrides at elaboration.
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : gen_bad_width
        $error("multiplier_32x32: WIDTH must be even and at least 4");
    end
    if (LATENCY != 3) begin : gen_bad_latency
        $error("multiplier_32x32: LATENCY is fixed at 3 by the pipeline");
    end

    // Stage 1: input registers.
    logic             s1_valid_d, s1_valid_q;
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;

    // Stage 2: partial product registers.
    logic             s2_valid_d, s2_valid_q;
    logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
    logic [WIDTH-1:0] pp_ll_d, pp_ll_q;
    logic [WIDTH-1:0] pp_lh_d, pp_lh_q;
    logic [WIDTH-1:0] pp_hl_d, pp_hl_q;
    logic [WIDTH-1:0] pp_hh_d, pp_hh_q;

    // Stage 3: result registers.
    logic [WIDTH:0]     mid_sum;
    logic               out_valid_d, out_valid_q;
    logic [2*WIDTH-1:0] p_d, p_q;

    // Stage 1 next state: capture operands and their qualifier.
    always_comb begin
        a_d        = a;
        b_d        = b;
        s1_valid_d = in_valid;
    end

    // Stage 1 state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    mult_half #(.H(H)) u_mul_ll (.x(a_q[H-1:0]),     .y(b_q[H-1:0]),     .z(pp_ll));
    mult_half #(.H(H)) u_mul_lh (.x(a_q[H-1:0]),     .y(b_q[WIDTH-1:H]), .z(pp_lh));
    mult_half #(.H(H)) u_mul_hl (.x(a_q[WIDTH-1:H]), .y(b_q[H-1:0]),     .z(pp_hl));
    mult_half #(.H(H)) u_mul_hh (.x(a_q[WIDTH-1:H]), .y(b_q[WIDTH-1:H]), .z(pp_hh));

    // Stage 2 next state: forward the four partial products and the valid bit.
    always_comb begin
        pp_ll_d    = pp_ll;
        pp_lh_d    = pp_lh;
        pp_hl_d    = pp_hl;
        pp_hh_d    = pp_hh;
        s2_valid_d = s1_valid_q;
    end

    // Stage 2 state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_ll_q    <= '0;
            pp_lh_q    <= '0;
            pp_hl_q    <= '0;
            pp_hh_q    <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            pp_ll_q    <= pp_ll_d;
            pp_lh_q    <= pp_lh_d;
            pp_hl_q    <= pp_hl_d;
            pp_hh_q    <= pp_hh_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Stage 3 next state: the cross terms sum to WIDTH+1 bits; the carry is kept
    // and the term is placed at bit H, while hh:ll concatenates without overlap.
    always_comb begin
        mid_sum     = {1'b0, pp_lh_q} + {1'b0, pp_hl_q};
        p_d         = {pp_hh_q, pp_ll_q} + {{(H-1){1'b0}}, mid_sum, {H{1'b0}}};
        out_valid_d = s2_valid_q;
    end

    // Stage 3 state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_32x32.sv
// Scoreboard bench for multiplier_32x32: the driver queues expected products
// with their issue cycle, and a monitor pops and checks every valid output.
module tb_multiplier_32x32;
    import multiplier_32x32_pkg::*;

    localparam int unsigned W = MUL_WIDTH;

    typedef struct {
        product_t    prod;
        int unsigned cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic [2*W-1:0] p;

    exp_t        sb[$];
    int unsigned cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    multiplier_32x32 #(
        .WIDTH   (MUL_WIDTH),
        .LATENCY (MUL_LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .p         (p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid output must match the oldest queued expectation,
    // and must arrive exactly MUL_LATENCY cycles after it was issued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_out_valid: got p=%h with out_valid=1, required no output",
                             p);
                end else begin
                    e = sb.pop_front();
                    if (p !== e.prod || (cyc - e.cyc) != MUL_LATENCY) begin
                        errors++;
                        $display("FAIL product: got p=%h latency=%0d, required p=%h latency=%0d",
                                 p, cyc - e.cyc, e.prod, MUL_LATENCY);
                    end
                end
            end else if (out_valid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL out_valid_known: got %b, required 0 or 1", out_valid);
            end
        end
    end

    task automatic check_val(input string name, input logic [2*W-1:0] got,
                             input logic [2*W-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic v,
                         input product_t e);
        @(negedge clk);
        a        = ai;
        b        = bi;
        in_valid = v;
        if (v) sb.push_back('{prod: e, cyc: cyc});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue('0, '0, 1'b0, '0);
    endtask

    // Bounded wait for all queued results; an expired bound counts as a failure.
    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        idle(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    logic [W-1:0] va[6];
    logic [W-1:0] vb[6];
    product_t     vp[6];

    initial begin
        va[0] = 32'h0000_0003; vb[0] = 32'h0000_0004; vp[0] = 64'h0000_0000_0000_000C;
        va[1] = 32'h0000_0000; vb[1] = 32'h1234_5678; vp[1] = 64'h0000_0000_0000_0000;
        va[2] = 32'h0000_0001; vb[2] = 32'hFFFF_FFFF; vp[2] = 64'h0000_0000_FFFF_FFFF;
        va[3] = 32'h0000_FFFF; vb[3] = 32'h0000_AAAA; vp[3] = 64'h0000_0000_AAA9_5556;
        va[4] = 32'hFFFF_FFFF; vb[4] = 32'hFFFF_FFFF; vp[4] = 64'hFFFF_FFFE_0000_0001;
        va[5] = 32'h1234_5678; vb[5] = 32'h8765_4321; vp[5] = 64'h09A0_CD05_70B8_8D78;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check_val("reset_p", p, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single shots, each fully drained before the next.
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], 1'b1, vp[i]);
            drain("single");
        end

        // Back-to-back stream of the same six pairs.
        for (int i = 0; i < 6; i++) issue(va[i], vb[i], 1'b1, vp[i]);
        drain("stream");

        // Reset mid-stream: a prior result is on the output when reset hits.
        issue(va[5], vb[5], 1'b1, vp[5]);
        issue(va[3], vb[3], 1'b1, vp[3]);
        issue(va[4], vb[4], 1'b1, vp[4]);
        issue(va[0], vb[0], 1'b1, vp[0]);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_val("rst_async_out_valid", {63'b0, out_valid}, 64'd0);
        check_val("rst_async_p", p, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check_val("rst_held_out_valid", {63'b0, out_valid}, 64'd0);
        check_val("rst_held_p", p, 64'd0);
        rst_n = 1'b1;
        idle(6);
        issue(va[5], vb[5], 1'b1, vp[5]);
        drain("post_reset");

        // Random regression against a 64-bit reference product.
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rv;
            ra = $urandom;
            rb = $urandom;
            rv = ($urandom_range(0, 9) < 7);
            issue(ra, rb, rv, product_t'(ra) * product_t'(rb));
        end
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiplier_32x32.md
Name: multiplier_32x32

Overview:
- Pipelined unsigned 32x32 -> 64-bit integer multiplier.
- Accepts one operand pair per clock and returns the full-width product a fixed 3 cycles later.
- Used as the shared multiply datapath block; no stall or backpressure.

Parameters:
- WIDTH, 32, operand width in bits; must be even; product width is 2*WIDTH.
- LATENCY, 3, input-to-output delay in clock cycles; fixed by the pipeline structure and exposed for bench and integration use only.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a and b this cycle.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  p holds a valid product this cycle.
- p  output  2*WIDTH  unsigned product a*b; exact, never truncated.

Behaviour:
- Reset: rst_n low asynchronously clears all pipeline registers; out_valid=0 and p=0 while reset is held and until the first valid result emerges.
- Deassertion of rst_n is synchronised externally; the block has no sync logic of its own.
- Unsigned arithmetic only; no overflow is possible in the 2*WIDTH result.
- Stage 1 (input register): capture a, b and in_valid.
- Stage 2 (partial products): split each operand into halves (H = WIDTH/2).
  - Compute four HxH products: aL*bL, aL*bH, aH*bL, aH*bH.
  - Register all four along with the valid bit.
- Stage 3 (sum): p = aH*bH<<WIDTH + (aL*bH + aH*bL)<<H + aL*bL.
  - Carry out of the middle-term addition (H+WIDTH+1 bits) must be preserved.
  - Register the result into p and out_valid.
- Latency: operands presented with in_valid=1 in cycle N appear on p with out_valid=1 in cycle N+3.
- Throughput: one operation per cycle; back-to-back valids produce back-to-back results in order.
- When in_valid=0, the datapath still advances.
  - p still updates, but its value is don't-care for consumers.
  - out_valid must be 0 in that slot.
  - Registers may be clock-gated by valid to save power, provided out_valid timing is unchanged.
- Reset mid-operation: all in-flight operations are discarded and out_valid drops immediately (asynchronously). No result from before reset ever appears afterwards.
- X on a or b with in_valid=0 must not propagate to out_valid.

Decomposition:
- Shared package: MUL_WIDTH=32 and MUL_LATENCY=3 constants, plus a product_t typedef (logic [63:0]).
- One sub-module, mult_half: combinational unsigned HxH -> 2H multiplier.
  - Instantiated four times in stage 2.
  - Behavioural '*' is acceptable; synthesis maps it to DSP or array logic.

Test Plan:
- 3 x 4 with in_valid=1, single shot: out_valid high exactly 3 cycles later, p=64'h0000_0000_0000_000C.
- Zero and identity:
  - 0 x 32'h1234_5678 -> p=0.
  - 1 x 32'hFFFF_FFFF -> p=64'h0000_0000_FFFF_FFFF.
- Half-width and maximum operands:
  - 32'h0000_FFFF x 32'h0000_AAAA -> p=64'h0000_0000_AAA9_5556.
  - 32'hFFFF_FFFF x 32'hFFFF_FFFF -> p=64'hFFFF_FFFE_0000_0001 (exercises middle-term carry).
- Mixed operand 32'h1234_5678 x 32'h8765_4321 -> p=64'h09A0_CD05_70B8_8D78. Then stream all six pairs above on consecutive cycles: results appear in order on six consecutive cycles starting 3 cycles after the first.
- Reset mid-stream:
  - Issue three valid ops, then pulse rst_n low between clock edges.
  - out_valid=0 and p=0 immediately; none of the three results ever emerge.
  - The next op after release returns correctly after 3 cycles.
- Random regression: 10k random (a, b, in_valid) with ~70% valid density, checked against a 64-bit reference model delayed 3 cycles; out_valid must match the delayed in_valid exactly.
